// File: rtl/ps2_pkg.sv
// Shared PS/2 byte codes and the host command sequencer state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_ACK          = 8'hFA;
  localparam logic [7:0] PS2_RESEND       = 8'hFE;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_TX  = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } ps2_cmd_state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Saturating response timer: cleared on tx completion, counts while enabled,
// flags expiry on the cycle it holds LIMIT-1.
module ps2_timeout_timer #(
  parameter int LIMIT = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  import ps2_pkg::*;

  localparam int             W    = clog2_min1(LIMIT);
  localparam logic [W-1:0]   LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         count <= '0;
    else if (clear)                    count <= '0;
    else if (enable && count != LAST)  count <= count + W'(1);
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/ps2_host_cmd.sv
// Host-to-keyboard command sequencer: sends a 1- or 2-byte command, waits for
// ACK/resend/timeout with bounded retries, and forwards all other bytes as keys.
module ps2_host_cmd #(
  parameter int ACK_TIMEOUT_CYCLES = 2_000_000,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_idle,
  input  logic       tx_finished,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] key_data,
  output logic       key_valid,
  output logic       done_tick,
  output logic       err_tick
);
  import ps2_pkg::*;

  localparam int            RW         = clog2_min1(MAX_RETRIES + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES);

  ps2_cmd_state_t state, state_n;
  logic [7:0]     cmd_q, arg_q;
  logic           has_arg_q, byte_sel;
  logic [RW-1:0]  retry;
  logic           accept, advance, retry_inc, tmr_clear, timeout;
  logic           ack_seen, nak_seen, consume;
  logic [7:0]     cur_byte;

  assign ack_seen = rx_done && (rx_data == PS2_ACK);
  assign nak_seen = rx_done && (rx_data == PS2_RESEND);
  // Only a pending response may swallow ACK/RESEND; anywhere else they are keys.
  assign consume  = (state == WAIT_ACK) && (ack_seen || nak_seen);
  assign cur_byte = byte_sel ? arg_q : cmd_q;

  ps2_timeout_timer #(.LIMIT(ACK_TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (state == WAIT_ACK),
    .expired(timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    tx_wr     = 1'b0;
    tx_data   = 8'h00;
    done_tick = 1'b0;
    err_tick  = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    retry_inc = 1'b0;
    tmr_clear = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        tx_data = cur_byte;
        if (tx_idle) begin
          tx_wr   = 1'b1;
          state_n = WAIT_TX;
        end
      end
      WAIT_TX: begin
        tx_data = cur_byte;
        if (tx_finished) begin
          tmr_clear = 1'b1;
          state_n   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // ACK takes priority over a coincident timeout; RESEND plus timeout is one retry.
        if (ack_seen) begin
          if (!byte_sel && has_arg_q) begin
            advance = 1'b1;
            state_n = SEND;
          end else begin
            state_n = DONE;
          end
        end else if (nak_seen || timeout) begin
          if (retry == RETRY_LAST) begin
            state_n = ERROR;
          end else begin
            retry_inc = 1'b1;
            state_n   = SEND;
          end
        end
      end
      DONE: begin
        done_tick = 1'b1;
        state_n   = IDLE;
      end
      ERROR: begin
        err_tick = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q     <= 8'h00;
      arg_q     <= 8'h00;
      has_arg_q <= 1'b0;
      byte_sel  <= 1'b0;
      retry     <= '0;
      key_valid <= 1'b0;
      key_data  <= 8'h00;
    end else begin
      if (accept) begin
        cmd_q     <= cmd_byte;
        arg_q     <= cmd_arg;
        has_arg_q <= cmd_has_arg;
        byte_sel  <= 1'b0;
        retry     <= '0;
      end else if (advance) begin
        byte_sel <= 1'b1;
        retry    <= '0;
      end else if (retry_inc) begin
        retry <= retry + RW'(1);
      end
      key_valid <= rx_done && !consume;
      if (rx_done && !consume) key_data <= rx_data;
    end
  end

endmodule
